// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Glyphs are active-high, bit 0 = segment a through bit 6 = segment g.
package seg_pkg;

  typedef enum logic {
    StBlank = 1'b0,
    StDrive = 1'b1
  } scan_state_e;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex-to-segment decode; output is active-high, bit 7 = dp.
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  assign o_seg = i_blank ? 8'h00 : {i_dp, HEX_GLYPH[i_nibble]};

endmodule

// File: rtl/seg_mux_scanner.sv
// Four-digit multiplexed display scanner with per-slot anti-ghost blanking,
// frame-synchronous value loading and leading-zero suppression.
module seg_mux_scanner
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 25000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic        blank_lz,
  output logic [3:0]  io_sel,
  output logic [7:0]  io_seg,
  output logic        frame_tick
);

  localparam int unsigned     CNT_W      = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [3:0]      SEL_OFF    = {4{ACTIVE_LOW}};
  localparam logic [7:0]      SEG_OFF    = {8{ACTIVE_LOW}};

  scan_state_e      r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;
  logic             r_tick;
  logic [3:0]       r_sel;
  logic [7:0]       r_seg;
  logic [15:0]      r_act_data;
  logic [3:0]       r_act_dp;
  logic [15:0]      r_pend_data;
  logic [3:0]       r_pend_dp;
  logic             r_pend_full;

  logic             w_slot_end;
  logic             w_wrap;
  logic             w_lz_blank;
  logic [7:0]       w_seg_dec;
  logic [3:0]       w_sel_on;
  logic [7:0]       w_seg_on;
  logic             w_xfer;

  assign w_slot_end = (r_state == StBlank) ? (r_cnt == BLANK_LAST) : (r_cnt == DRIVE_LAST);
  assign w_wrap     = (r_state == StDrive) && w_slot_end && (r_idx == 2'd3);
  // A digit is suppressed only when it and every more significant nibble are zero.
  assign w_lz_blank = blank_lz && (r_idx != 2'd0) && ((r_act_data >> {r_idx, 2'b00}) == 16'h0);

  hex7seg_decode u_decode (
    .i_nibble (r_act_data[{r_idx, 2'b00} +: 4]),
    .i_dp     (r_act_dp[r_idx]),
    .i_blank  (w_lz_blank),
    .o_seg    (w_seg_dec)
  );

  assign w_sel_on = (r_state == StDrive) ? (4'b0001 << r_idx) : 4'h0;
  assign w_seg_on = (r_state == StDrive) ? w_seg_dec : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StBlank;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_tick  <= 1'b0;
      r_sel   <= SEL_OFF;
      r_seg   <= SEG_OFF;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        if (r_state == StBlank) begin
          r_state <= StDrive;
        end else begin
          r_state <= StBlank;
          r_idx   <= r_idx + 2'd1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Outputs lag the state that produces them by one cycle.
      r_wrap <= w_wrap;
      r_tick <= r_wrap;
      r_sel  <= w_sel_on ^ SEL_OFF;
      r_seg  <= w_seg_on ^ SEG_OFF;
    end
  end

  assign w_xfer = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_data  <= 16'h0;
      r_act_dp    <= 4'h0;
      r_pend_data <= 16'h0;
      r_pend_dp   <= 4'h0;
      r_pend_full <= 1'b0;
    end else if (r_tick && r_pend_full) begin
      r_act_data  <= r_pend_data;
      r_act_dp    <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_xfer) begin
      r_pend_data <= load_data;
      r_pend_dp   <= load_dp;
      r_pend_full <= 1'b1;
    end
  end

  assign load_ready = ~r_pend_full;
  assign io_sel     = r_sel;
  assign io_seg     = r_seg;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_mux_scanner.sv
// Self-checking bench: directed and random loads against a frame-position reference model.
module tb_seg_mux_scanner;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic [3:0]  load_dp = 4'h0;
  logic        blank_lz = 1'b0;
  logic        load_ready;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;
  logic        frame_tick;

  int n_checks = 0;
  int n_fails = 0;

  // Reference model: k = clock edges since reset release.
  int          k;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_full, m_tick;
  logic [3:0]  e_sel;
  logic [7:0]  e_seg;
  logic        e_tick;

  seg_mux_scanner #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .blank_lz   (blank_lz),
    .io_sel     (io_sel),
    .io_seg     (io_seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    string      s;
    logic [6:0] g;
    g = '0;
    case (n)
      4'h0: s = "abcdef";
      4'h1: s = "bc";
      4'h2: s = "abdeg";
      4'h3: s = "abcdg";
      4'h4: s = "bcfg";
      4'h5: s = "acdfg";
      4'h6: s = "acdefg";
      4'h7: s = "abc";
      4'h8: s = "abcdefg";
      4'h9: s = "abcdfg";
      4'hA: s = "abcefg";
      4'hB: s = "cdefg";
      4'hC: s = "adef";
      4'hD: s = "bcdeg";
      4'hE: s = "adefg";
      default: s = "aefg";
    endcase
    for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b1;
    return g;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s k=%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_act = 16'h0;
    m_act_dp = 4'h0;
    m_pend = 16'h0;
    m_pend_dp = 4'h0;
    m_full = 1'b0;
    m_tick = 1'b0;
  endtask

  task automatic step();
    int p, slot;
    logic [3:0] nib;
    logic lzb;
    @(posedge clk);
    k++;
    p = (k - 1) % FRAME;
    slot = p / DC;
    if ((p % DC) < BC) begin
      e_sel = 4'hF;
      e_seg = 8'hFF;
    end else begin
      e_sel = ~(4'b0001 << slot);
      nib = 4'(m_act >> (4 * slot));
      lzb = blank_lz && (slot != 0) && ((m_act >> (4 * slot)) == 16'h0);
      e_seg = lzb ? 8'hFF : ~{m_act_dp[slot], glyph(nib)};
    end
    e_tick = (k >= 2) && (((k - 1) % FRAME) == 0);
    if (m_tick && m_full) begin
      m_act = m_pend;
      m_act_dp = m_pend_dp;
      m_full = 1'b0;
    end else if (load_valid && !m_full) begin
      m_pend = load_data;
      m_pend_dp = load_dp;
      m_full = 1'b1;
    end
    m_tick = e_tick;
    @(negedge clk);
    check("sel", {4'h0, io_sel}, {4'h0, e_sel});
    check("seg", io_seg, e_seg);
    check("tick", {7'h0, frame_tick}, {7'h0, e_tick});
    check("ready", {7'h0, load_ready}, {7'h0, !m_full});
  endtask

  // Offers one value and holds valid until the model accepts it.
  task automatic offer(input logic [15:0] d, input logic [3:0] dp);
    load_data = d;
    load_dp = dp;
    load_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME && m_full; i++) step();
    step();
    load_valid = 1'b0;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_sel"}, {4'h0, io_sel}, 8'h0F);
    check({tag, "_seg"}, io_seg, 8'hFF);
    check({tag, "_tick"}, {7'h0, frame_tick}, 8'h00);
    check({tag, "_ready"}, {7'h0, load_ready}, 8'h01);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #10 check_off("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle scanning of the reset value.
    repeat (40) step();

    // Mid-frame load, then a held second value while not ready.
    offer(16'h12AF, 4'b0100);
    load_data = 16'hFFFF;
    load_dp = 4'hF;
    load_valid = 1'b1;
    repeat (60) step();
    load_valid = 1'b0;
    repeat (40) step();

    // Leading-zero suppression.
    blank_lz = 1'b1;
    offer(16'h0050, 4'h0);
    repeat (70) step();
    offer(16'h0000, 4'h0);
    repeat (70) step();

    // Randomized loads and live blank_lz toggling.
    for (int i = 0; i < 1200; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0: load_data = 16'($urandom);
        1: load_data = 16'($urandom) >> (4 * $urandom_range(1, 3));
        default: load_data = 16'h0;
      endcase
      load_dp = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      step();
    end
    load_valid = 1'b0;

    // Asynchronous reset mid-slot with a value pending.
    offer(16'h8888, 4'hF);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1 check_off("async_reset");
    @(negedge clk);
    check_off("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (70) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seg_mux_scanner.md
SEG_MUX_SCANNER -- requirements
Module: seg_mux_scanner

Interface
REQ-001 Parameter DIGIT_CYCLES, default 25000, SHALL set clk cycles per digit slot (4 kHz slot, 1 kHz frame at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 1000, SHALL set anti-ghost blank cycles at the start of each slot; legal range 1..DIGIT_CYCLES-1.
REQ-003 Parameter ACTIVE_LOW, default 1, SHALL set the polarity of io_sel and io_seg (1 means lit/selected is 0).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 load_valid  in  1  new display value offered.
REQ-007 load_ready  out  1  block can accept a value.
REQ-008 load_data  in  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-009 load_dp  in  4  decimal point per digit; bit n is digit n.
REQ-010 blank_lz  in  1  leading-zero suppression enable, sampled live.
REQ-011 io_sel  out  4  digit select, one-hot in the logical sense; bit n is digit n.
REQ-012 io_seg  out  8  segments; [6:0] is a..g, [7] is dp.
REQ-013 frame_tick  out  1  single-cycle pulse at each frame boundary.

Function
REQ-014 FSM states SHALL be BLANK and DRIVE, with a 2-bit digit index 0..3 and a slot counter.
REQ-015 BLANK SHALL last BLANK_CYCLES cycles, with all io_sel and all io_seg logically off; it then goes to DRIVE.
REQ-016 DRIVE SHALL last DIGIT_CYCLES-BLANK_CYCLES cycles, selecting only the current digit with its decoded segments; it then goes to BLANK and the index increments.
REQ-017 The index SHALL wrap 3->0; frame_tick SHALL pulse on the cycle the index wraps.
REQ-018 Decode SHALL be full hex 0-F with standard glyphs (0=abcdef, 1=bc, 7=abc, 8=all, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg); dp SHALL come from the active dp bit.
REQ-019 When blank_lz=1, a digit SHALL be blanked (segments and dp off, select still driven) if its nibble and all higher nibbles are 0; digit 0 SHALL never be blanked.
REQ-020 io_sel, io_seg and frame_tick SHALL be registered; each changes one cycle after the state/index change that causes it.
REQ-021 Handshake: a transfer SHALL occur when load_valid and load_ready are both 1 on a clk edge; load_data and load_dp SHALL then be captured into a pending register.
REQ-022 load_ready SHALL go 0 the cycle after a transfer and stay 0 while pending is full.
REQ-023 A full pending register SHALL move to the active register on the frame_tick cycle only, so a frame never mixes values; load_ready SHALL return to 1 the following cycle.
REQ-024 With no pending value at a frame boundary, active data SHALL be unchanged.
REQ-025 load_valid held high while load_ready=0 SHALL have no effect and SHALL NOT be queued.

Reset
REQ-026 On rst_n low: state BLANK, index 0, counter 0, active and pending registers 0, pending empty.
REQ-027 On rst_n low: load_ready=1, frame_tick=0, io_sel and io_seg all logically off.
REQ-028 Reset mid-frame SHALL discard any pending value; scanning SHALL restart at digit 0 BLANK on the first edge after release.

Structure
REQ-029 Package seg_pkg SHALL hold the state encoding and the 16-entry hex-to-segment constant table.
REQ-030 Sub-module hex7seg_decode (combinational: nibble, dp, blank in; 8-bit segments out) SHALL perform the decode; polarity SHALL be applied in seg_mux_scanner.

Verification (bench uses DIGIT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-031 Reset release, no load -> io_sel=4'hF, io_seg=8'hFF for 2 cycles, then io_sel 1110/1101/1011/0111 each 6 cycles with glyph 0 (io_seg=8'hC0); frame_tick every 32 cycles.
REQ-032 Load 16'h12AF, dp=4'b0100 mid-frame -> load_ready low until the next frame_tick+1; the next frame shows F,A,2(with dp),1 on digits 0..3; the current frame is unchanged.
REQ-033 Second load_valid held while load_ready=0 with 16'hFFFF -> ignored; it is accepted only once ready returns and appears one frame later.
REQ-034 blank_lz=1, data 16'h0050 -> digits 3 and 2 blank (io_seg=8'hFF while selected); digit 1 shows 5; digit 0 shows 0.
REQ-035 rst_n pulsed low mid-slot with a value pending -> outputs off immediately (asynchronous); pending discarded; scanning restarts at digit 0 showing 0.
